// File: rtl/signal_capture.sv
// Single-shot capture of a sample stream into a 2**NB_ADDR-deep RAM, with burst playback of the stored record.
// Latency: arm to capture takes 1 cycle. Read request to first word takes 2 cycles: a registered RAM read, then a registered output.
// Backpressure: none. Samples are taken whenever i_valid is high in CAPTURE, and playback streams one word per cycle without stalls.
module signal_capture #(
  parameter int NB_DATA = 16,
  parameter int NB_ADDR = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_sample,
  input  logic               i_valid,
  input  logic               i_arm,
  input  logic               i_read,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic               o_rd_valid,
  output logic               o_rd_last
);

  localparam int DEPTH = 2 ** NB_ADDR;
  localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE, READ} state_t;

  state_t             state, state_nxt;
  logic [NB_ADDR-1:0] wr_addr, wr_addr_nxt;
  logic [NB_ADDR-1:0] rd_addr, rd_addr_nxt;
  logic               wr_en;
  logic               rd_en;

  logic [NB_DATA-1:0] mem [DEPTH];
  logic [NB_DATA-1:0] ram_q;
  logic               rd_vld_q;
  logic               rd_last_q;

  // State and address counters
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state   <= IDLE;
      wr_addr <= '0;
      rd_addr <= '0;
    end else begin
      state   <= state_nxt;
      wr_addr <= wr_addr_nxt;
      rd_addr <= rd_addr_nxt;
    end
  end

  // Next state and counter updates. In DONE, i_arm takes priority over i_read.
  always_comb begin
    state_nxt   = state;
    wr_addr_nxt = wr_addr;
    rd_addr_nxt = rd_addr;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    case (state)
      IDLE: begin
        if (i_arm) begin
          state_nxt   = CAPTURE;
          wr_addr_nxt = '0;
        end
      end
      CAPTURE: begin
        if (i_valid) begin
          wr_en       = 1'b1;
          wr_addr_nxt = wr_addr + 1'b1;
          if (wr_addr == LAST_ADDR) state_nxt = DONE;
        end
      end
      DONE: begin
        if (i_arm) begin
          state_nxt   = CAPTURE;
          wr_addr_nxt = '0;
        end else if (i_read) begin
          state_nxt   = READ;
          rd_addr_nxt = '0;
        end
      end
      READ: begin
        rd_en       = 1'b1;
        rd_addr_nxt = rd_addr + 1'b1;
        if (rd_addr == LAST_ADDR) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-port RAM with a registered read. Writes and reads never coincide. Contents survive reset.
  always_ff @(posedge i_clock) begin
    if (wr_en) mem[wr_addr] <= i_sample;
    else if (rd_en) ram_q <= mem[rd_addr];
  end

  // Playback pipeline. o_rd_data holds its value between bursts.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_last  <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      rd_vld_q   <= rd_en;
      rd_last_q  <= rd_en && (rd_addr == LAST_ADDR);
      o_rd_valid <= rd_vld_q;
      o_rd_last  <= rd_last_q;
      if (rd_vld_q) o_rd_data <= ram_q;
    end
  end

  assign o_busy = (state == CAPTURE) || (state == READ);
  assign o_done = (state == DONE);

endmodule

// File: tb/tb_signal_capture.sv
// Directed bench for signal_capture: capture patterns, playback bursts, reset abort and command priority.
// Latency: checks 1-cycle arm, 2-cycle read-to-first-word, done one cycle after the last capture write.
// Backpressure: none exercised; the DUT streams without stalls and the bench samples every cycle.
module tb_signal_capture;

    localparam int NB_DATA = 16;
    localparam int NB_ADDR = 10;
    localparam int DEPTH   = 1024;

    logic               i_clock;
    logic               i_reset;
    logic [NB_DATA-1:0] i_sample;
    logic               i_valid;
    logic               i_arm;
    logic               i_read;
    logic               o_busy;
    logic               o_done;
    logic [NB_DATA-1:0] o_rd_data;
    logic               o_rd_valid;
    logic               o_rd_last;

    int tests = 0;
    int fails = 0;

    signal_capture #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_sample  (i_sample),
        .i_valid   (i_valid),
        .i_arm     (i_arm),
        .i_read    (i_read),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_rd_data (o_rd_data),
        .o_rd_valid(o_rd_valid),
        .o_rd_last (o_rd_last)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    function automatic logic [NB_DATA-1:0] pat_val(input int pat, input int j);
        logic [NB_DATA-1:0] jj;
        jj = NB_DATA'(j);
        case (pat)
            0:       return jj;
            1:       return 16'hA5A5 ^ jj;
            2:       return 16'h5A00 + jj;
            default: return 16'hFFFF ^ jj;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic arm();
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        chk("arm_busy", o_busy, 1'b1);
        chk("arm_done", o_done, 1'b0);
    endtask

    task automatic capture(input int pat, input int n, input int gap,
                           input bit inject, input bit expect_done);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) tick();
            if (expect_done && i == n - 1) chk("cap_done_early", o_done, 1'b0);
            i_sample = pat_val(pat, i);
            i_valid  = 1'b1;
            if (inject && i == 300) begin
                i_arm  = 1'b1;
                i_read = 1'b1;
            end
            tick();
            i_valid = 1'b0;
            i_arm   = 1'b0;
            i_read  = 1'b0;
        end
        if (expect_done) begin
            chk("cap_done", o_done, 1'b1);
            chk("cap_busy", o_busy, 1'b0);
        end
    endtask

    task automatic do_read(input int pat, input bit inject);
        int nwords;
        nwords = 0;
        i_read = 1'b1;
        tick();
        i_read = 1'b0;
        chk("rd_busy", o_busy, 1'b1);
        chk("rd_done", o_done, 1'b0);
        for (int cyc = 1; cyc <= DEPTH + 2; cyc++) begin
            if (inject && cyc == 100) begin
                i_arm  = 1'b1;
                i_read = 1'b1;
            end
            tick();
            i_arm  = 1'b0;
            i_read = 1'b0;
            chk("rd_valid", o_rd_valid, (cyc >= 2 && cyc <= DEPTH + 1));
            chk("rd_excl", (o_busy && o_done), 1'b0);
            if (o_rd_valid) begin
                nwords++;
                chk("rd_data", o_rd_data, pat_val(pat, cyc - 2));
                chk("rd_last", o_rd_last, (cyc - 2 == DEPTH - 1));
            end else begin
                chk("rd_last_idle", o_rd_last, 1'b0);
            end
            if (cyc == DEPTH + 1) chk("rd_done_by_last", o_done, 1'b1);
        end
        chk("rd_count", nwords, DEPTH);
        chk("rd_hold", o_rd_data, pat_val(pat, DEPTH - 1));
        chk("rd_done_after", o_done, 1'b1);
    endtask

    initial begin
        int seen;
        i_reset  = 1'b0;
        i_sample = '0;
        i_valid  = 1'b0;
        i_arm    = 1'b0;
        i_read   = 1'b0;

        #2;
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_data", o_rd_data, 16'h0000);
        chk("rst_valid", o_rd_valid, 1'b0);
        chk("rst_last", o_rd_last, 1'b0);
        tick();
        tick();
        i_reset = 1'b1;
        tick();

        i_read = 1'b1;
        tick();
        i_read = 1'b0;
        seen = 0;
        for (int c = 0; c < 2000; c++) begin
            if (o_rd_valid || o_busy) seen++;
            tick();
        end
        chk("idle_read_ignored", seen, 0);
        chk("idle_done", o_done, 1'b0);

        arm();
        capture(0, DEPTH, 0, 1'b0, 1'b1);
        do_read(0, 1'b0);

        arm();
        capture(1, DEPTH, 2, 1'b1, 1'b1);
        do_read(1, 1'b1);

        i_arm  = 1'b1;
        i_read = 1'b1;
        tick();
        i_arm  = 1'b0;
        i_read = 1'b0;
        chk("both_busy", o_busy, 1'b1);
        chk("both_done", o_done, 1'b0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (o_rd_valid) seen++;
            tick();
        end
        chk("both_no_read", seen, 0);

        capture(3, 512, 0, 1'b0, 1'b0);
        chk("partial_busy", o_busy, 1'b1);
        i_reset = 1'b0;
        #1;
        chk("async_rst_busy", o_busy, 1'b0);
        chk("async_rst_done", o_done, 1'b0);
        tick();
        i_reset = 1'b1;
        tick();
        chk("post_rst_busy", o_busy, 1'b0);
        chk("post_rst_done", o_done, 1'b0);

        arm();
        capture(2, DEPTH, 0, 1'b0, 1'b1);
        do_read(2, 1'b0);
        do_read(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/signal_capture.md
# signal_capture

Capture buffer that records a stream of NB_DATA-bit samples (for example the FIR output) into a 1024-deep internal RAM, then plays the stored record back as a single burst. It is the write-side counterpart of the ROM-based signal generator: the generator replays a stored waveform into the filter, and this block stores the filter's response for later readout over the debug path. Capture is single-shot per arm, and the block never overwrites a completed record until it is re-armed.

## Interface
- NB_DATA, 16, sample width in bits.
- NB_ADDR, 10, address width; depth = 2**NB_ADDR (1024 at default).

- i_clock  in  1  sole clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-low reset. Asserts immediately; deasserts synchronously.
- i_sample  in  NB_DATA  sample to record.
- i_valid  in  1  i_sample is valid this cycle.
- i_arm  in  1  single-cycle request to start a new capture.
- i_read  in  1  single-cycle request to dump the stored record.
- o_busy  out  1  high in CAPTURE or READ.
- o_done  out  1  high in DONE, meaning a full record is stored and unread or re-readable.
- o_rd_data  out  NB_DATA  playback sample.
- o_rd_valid  out  1  o_rd_data is valid this cycle.
- o_rd_last  out  1  marks the final playback word; only ever high together with o_rd_valid.

## Operation
- FSM states: IDLE, CAPTURE, DONE, READ. Reset state is IDLE.
- IDLE
  - i_arm=1 moves to CAPTURE and sets wr_addr to 0.
  - i_read is ignored.
- CAPTURE
  - On each cycle with i_valid=1, write i_sample to RAM[wr_addr], then increment wr_addr.
  - Cycles with i_valid=0 write nothing and hold wr_addr; gaps are allowed.
  - The write to address DEPTH-1 moves to DONE. wr_addr wraps to 0 on that write and is unused afterward.
  - i_arm and i_read are ignored.
- DONE
  - i_read=1 moves to READ and sets rd_addr to 0.
  - i_arm=1 moves to CAPTURE and sets wr_addr to 0; the old record is overwritten as new samples arrive.
  - i_arm and i_read high in the same cycle: i_arm wins.
- READ
  - Issue one read address per cycle, rd_addr 0 through DEPTH-1, with no gaps and no backpressure.
  - After issuing DEPTH-1, return to DONE, so the record can be read again.
  - i_arm and i_read are ignored.
- RAM
  - Single-port is sufficient, since write and read never overlap.
  - Read is synchronous with a 1-cycle registered output.
  - RAM contents are not cleared by reset.
- Counters are NB_ADDR bits wide and use natural wrap. No arithmetic is applied to the data; samples are stored bit-exact.
- Reset in any state:
  - Return to IDLE and clear both address counters and all outputs.
  - A partial record is discarded logically: o_done stays 0 until a full capture completes.

## Timing
- Reset values: o_busy=0, o_done=0, o_rd_data=0, o_rd_valid=0, o_rd_last=0.
- Arm latency: with i_arm sampled at edge n, state is CAPTURE after edge n. The earliest recorded sample is the one presented with i_valid at edge n+1.
- Capture completion: the edge that writes the DEPTH-th valid sample sets o_done=1 and o_busy=0 in the following cycle.
- Read latency:
  - With i_read sampled at edge k, o_busy=1 and o_done=0 after edge k.
  - RAM[j] appears on o_rd_data with o_rd_valid=1 in the cycle after edge k+2+j, for j = 0 to DEPTH-1.
  - The result is exactly DEPTH consecutive valid cycles, with o_rd_last=1 on j=DEPTH-1 only.
- o_rd_valid falls the cycle after the last word. o_done returns to 1 in the same cycle that o_rd_last is presented or earlier, and is high no later than the cycle after.
- o_rd_data holds its last value when o_rd_valid=0. Its value is don't-care, except that it is 0 after reset.
- o_busy and o_done are never high simultaneously.

## Test plan
- Reset → all outputs 0, state IDLE. Pulse i_read in IDLE → no o_rd_valid within 2000 cycles.
- Arm, then feed 1024 samples with i_valid=1 continuously, values 0x0000..0x03FF → o_done rises one cycle after the last write. Pulse i_read → 1024 words 0x0000..0x03FF on consecutive cycles, o_rd_last on 0x03FF only, first word 2 cycles after i_read.
- Arm, then feed 1024 samples with i_valid asserted every third cycle (pattern 0xA5A5 XOR index) → o_done only after the 1024th valid sample; readout matches exactly with no gaps.
- Capture 512 samples, assert i_reset for 1 cycle → o_busy=0, o_done=0. Re-arm with a full 1024-sample capture → readout contains only the new data.
- In DONE, pulse i_arm and i_read together → CAPTURE entered, no readout. Pulse i_arm or i_read during CAPTURE or READ → no effect on counts or data.
- Read the same record twice back-to-back → both bursts are identical, and o_done returns to 1 between them.
